flag_reg_unit: RTL and testbench
================================

// Module: flag_reg_unit
// PURPOSE
//  Consumer end of the ALU flags interface: holds the CPU flag register FR (N,Z,C,V) and writes it from ALU flags under a per-flag mask.
//  Supports direct FR writes, and a FR save stack (push on interrupt entry, pop on return).
//  Evaluates 4-bit branch condition codes against the registered FR for the branch unit.
//  Sits between the ALU flags output and the decode/branch logic.
// PARAMETERS
//  FLAG_W       `FR_FLAG_W (4)  flag width; bits N=`N_FLAG(3) Z=`Z_FLAG(2) C=`C_FLAG(1) V=`V_FLAG(0)
//  STACK_DEPTH  4              FR save-stack entries (>=1)
// PORTS
//  clk        in   1                          rising-edge clock
//  rst_n      in   1                          async active-low reset
//  alu_flags  in   FLAG_W                     flags from ALU {N,Z,C,V}
//  flag_mask  in   FLAG_W                     per-flag update enable for alu_flags (0 = hold)
//  fr_we      in   1                          direct FR write strobe
//  fr_wdata   in   FLAG_W                     direct FR write data
//  push       in   1                          save FR to stack
//  pop        in   1                          restore FR from stack
//  err_clr    in   1                          clear sticky errors
//  cond       in   4                          condition code to evaluate
//  fr         out  FLAG_W                     current FR
//  cond_true  out  1                          cond satisfied by current FR
//  depth      out  $clog2(STACK_DEPTH+1)      stack entries in use
//  ovf_err    out  1                          sticky: push while full
//  unf_err    out  1                          sticky: pop while empty
// BEHAVIOUR
//  Reset (async, rst_n=0): fr=0, depth=0, ovf_err=0, unf_err=0; stack contents don't-care.
//  FR next-value priority, evaluated per cycle:
//   1) pop with depth>0 -> fr <= top entry; direct and ALU updates dropped.
//   2) fr_we -> fr <= fr_wdata; flag_mask ignored.
//   3) else per bit i: fr[i] <= flag_mask[i] ? alu_flags[i] : fr[i].
//  FR updates are visible on fr/cond_true on the cycle after the edge (1-cycle latency); no bypass from alu_flags.
//  push, depth<STACK_DEPTH: stack[depth] <= old fr (pre-update value of this cycle); depth+1. Same-cycle FR update still applies.
//  push, depth==STACK_DEPTH: no stack change; ovf_err <= 1; FR update still applies.
//  pop, depth==0: fr unchanged by pop; unf_err <= 1; priorities 2/3 then apply normally.
//  push & pop same cycle: stack, depth and errors unchanged; FR follows priorities 2/3 only.
//  err_clr clears both errors; a same-cycle new error wins (error stays 1).
//  cond_true is combinational from fr and cond (C = borrow after SUB):
//   0 AL 1 | 1 EQ Z | 2 NE ~Z | 3 CS C | 4 CC ~C | 5 MI N | 6 PL ~N | 7 VS V | 8 VC ~V
//   9 HI ~C&~Z | 10 LS C|Z | 11 GE N==V | 12 LT N!=V | 13 GT ~Z&(N==V) | 14 LE Z|(N!=V) | 15 NV 0
//  Reset asserted mid-operation clears everything immediately, including a pending push or pop.
// TESTING
//  Reset: rst_n=0 then 1 -> fr=0, depth=0, errors=0; cond=1 gives 0, cond=2 gives 1.
//  Masked update: alu_flags=4'b1111 with mask=4'b0101 -> next cycle fr=4'b0101; same-cycle cond_true reflects old fr.
//  Conditions: ALU SUB 3-5 flags {N=1,Z=0,C=1,V=0}, mask=F -> LT=1, GE=0, LS=1, HI=0, CS=1.
//  Nesting: fr=4'hA push; fr_we 4'h3 push; pop -> fr=3, depth=1; pop -> fr=A, depth=0.
//  Overflow/underflow: five pushes at depth 4 -> ovf_err=1, depth=4; pop at depth 0 -> unf_err=1; err_clr -> both 0.
//  Collisions: push+pop -> depth unchanged; pop+fr_we -> popped value wins; push+mask update -> old fr stacked, fr updated.

Source files
------------

// File: rtl/flag_reg_unit.sv
// flag_reg_unit
//   Holds the CPU flag register FR {N,Z,C,V}. FR is loaded from the ALU flags
//   under a per-flag mask, or written directly. A small save stack holds FR:
//   push on interrupt entry, pop on return. The unit also evaluates branch
//   condition codes against the registered FR.
//
// Ports
//   clk        rising-edge clock
//   rst_n      async active-low reset
//   alu_flags  flags from ALU {N,Z,C,V}
//   flag_mask  per-flag update enable for alu_flags (0 = hold)
//   fr_we      direct FR write strobe
//   fr_wdata   direct FR write data
//   push       save FR to stack
//   pop        restore FR from stack
//   err_clr    clear sticky errors
//   cond       condition code to evaluate
//   fr         current FR
//   cond_true  cond satisfied by current FR (combinational)
//   depth      stack entries in use
//   ovf_err    sticky: push while full
//   unf_err    sticky: pop while empty
module flag_reg_unit #(
  parameter int unsigned FLAG_W      = 4,
  parameter int unsigned STACK_DEPTH = 4,
  localparam int unsigned DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FLAG_W-1:0]  alu_flags,
  input  logic [FLAG_W-1:0]  flag_mask,
  input  logic               fr_we,
  input  logic [FLAG_W-1:0]  fr_wdata,
  input  logic               push,
  input  logic               pop,
  input  logic               err_clr,
  input  logic [3:0]         cond,
  output logic [FLAG_W-1:0]  fr,
  output logic               cond_true,
  output logic [DEPTH_W-1:0] depth,
  output logic               ovf_err,
  output logic               unf_err
);

  localparam int unsigned N_FLAG = 3;
  localparam int unsigned Z_FLAG = 2;
  localparam int unsigned C_FLAG = 1;
  localparam int unsigned V_FLAG = 0;
  localparam int unsigned IDX_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [3:0] {
    CC_AL, CC_EQ, CC_NE, CC_CS, CC_CC, CC_MI, CC_PL, CC_VS,
    CC_VC, CC_HI, CC_LS, CC_GE, CC_LT, CC_GT, CC_LE, CC_NV
  } cond_e;

  logic [FLAG_W-1:0]  fr_q, fr_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic [FLAG_W-1:0]  stack_q [STACK_DEPTH];

  logic               do_push, do_pop, full, empty, push_ok, pop_ok;
  logic [DEPTH_W-1:0] depth_m1;
  logic [IDX_W-1:0]   wr_idx, rd_idx;

  // A simultaneous push and pop cancel: neither touches the stack or errors.
  assign do_push  = push & ~pop;
  assign do_pop   = pop & ~push;
  assign full     = (depth_q == DEPTH_W'(STACK_DEPTH));
  assign empty    = (depth_q == '0);
  assign push_ok  = do_push & ~full;
  assign pop_ok   = do_pop & ~empty;
  assign depth_m1 = depth_q - DEPTH_W'(1);
  assign wr_idx   = depth_q[IDX_W-1:0];
  assign rd_idx   = depth_m1[IDX_W-1:0];

  always_comb begin
    fr_d    = (fr_q & ~flag_mask) | (alu_flags & flag_mask);
    depth_d = depth_q;
    if (pop_ok) begin
      fr_d = stack_q[rd_idx];
    end else if (fr_we) begin
      fr_d = fr_wdata;
    end
    if (push_ok) begin
      depth_d = depth_q + DEPTH_W'(1);
    end else if (pop_ok) begin
      depth_d = depth_m1;
    end
    // A new error in the same cycle as err_clr keeps the flag set.
    ovf_d = (do_push & full)  | (ovf_q & ~err_clr);
    unf_d = (do_pop  & empty) | (unf_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fr_q    <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      fr_q    <= fr_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack contents are don't-care after reset, so no reset is applied here;
  // the entry stored is the FR value before this cycle's update.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      stack_q[wr_idx] <= fr_q;
    end
  end

  logic n_f, z_f, c_f, v_f;
  assign n_f = fr_q[N_FLAG];
  assign z_f = fr_q[Z_FLAG];
  assign c_f = fr_q[C_FLAG];
  assign v_f = fr_q[V_FLAG];

  always_comb begin
    cond_true = 1'b0;
    case (cond_e'(cond))
      CC_AL: cond_true = 1'b1;
      CC_EQ: cond_true = z_f;
      CC_NE: cond_true = ~z_f;
      CC_CS: cond_true = c_f;
      CC_CC: cond_true = ~c_f;
      CC_MI: cond_true = n_f;
      CC_PL: cond_true = ~n_f;
      CC_VS: cond_true = v_f;
      CC_VC: cond_true = ~v_f;
      CC_HI: cond_true = ~c_f & ~z_f;
      CC_LS: cond_true = c_f | z_f;
      CC_GE: cond_true = (n_f == v_f);
      CC_LT: cond_true = (n_f != v_f);
      CC_GT: cond_true = ~z_f & (n_f == v_f);
      CC_LE: cond_true = z_f | (n_f != v_f);
      CC_NV: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

  assign fr      = fr_q;
  assign depth   = depth_q;
  assign ovf_err = ovf_q;
  assign unf_err = unf_q;

endmodule

// File: tb/tb_flag_reg_unit.sv
module tb_flag_reg_unit;

  localparam int unsigned SD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] alu_flags = '0;
  logic [3:0] flag_mask = '0;
  logic       fr_we = 1'b0;
  logic [3:0] fr_wdata = '0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic       err_clr = 1'b0;
  logic [3:0] cond = '0;
  logic [3:0] fr;
  logic       cond_true;
  logic [2:0] depth;
  logic       ovf_err;
  logic       unf_err;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int          m_fr;
  int          m_stack[$];
  bit          m_ovf, m_unf;

  flag_reg_unit #(.FLAG_W(4), .STACK_DEPTH(SD)) dut (
    .clk(clk), .rst_n(rst_n), .alu_flags(alu_flags), .flag_mask(flag_mask),
    .fr_we(fr_we), .fr_wdata(fr_wdata), .push(push), .pop(pop),
    .err_clr(err_clr), .cond(cond), .fr(fr), .cond_true(cond_true),
    .depth(depth), .ovf_err(ovf_err), .unf_err(unf_err)
  );

  always #5 clk = ~clk;

  function automatic bit cond_model(int f, int c);
    bit n, z, cy, v;
    n  = ((f / 8) % 2) == 1;
    z  = ((f / 4) % 2) == 1;
    cy = ((f / 2) % 2) == 1;
    v  = (f % 2) == 1;
    case (c)
      0:  return 1;
      1:  return z;
      2:  return !z;
      3:  return cy;
      4:  return !cy;
      5:  return n;
      6:  return !n;
      7:  return v;
      8:  return !v;
      9:  return !cy && !z;
      10: return cy || z;
      11: return n == v;
      12: return n != v;
      13: return !z && (n == v);
      14: return z || (n != v);
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_fr = 0;
    m_stack.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  // Applies the rules of one clock edge to the model using the current inputs.
  task automatic model_edge();
    int  nfr;
    bit  popped, oset, uset;
    popped = 0; oset = 0; uset = 0;
    nfr = m_fr;
    if (pop && !push) begin
      if (m_stack.size() > 0) begin
        nfr = m_stack.pop_back();
        popped = 1;
      end else uset = 1;
    end
    if (!popped) begin
      if (fr_we) nfr = int'(fr_wdata);
      else begin
        nfr = 0;
        for (int i = 0; i < 4; i++) begin
          if (flag_mask[i]) nfr += int'(alu_flags[i]) << i;
          else              nfr += ((m_fr >> i) & 1) << i;
        end
      end
    end
    if (push && !pop) begin
      if (m_stack.size() < SD) m_stack.push_back(m_fr);
      else oset = 1;
    end
    m_ovf = oset || (m_ovf && !err_clr);
    m_unf = uset || (m_unf && !err_clr);
    m_fr  = nfr;
  endtask

  task automatic idle();
    alu_flags = '0; flag_mask = '0; fr_we = 0; fr_wdata = '0;
    push = 0; pop = 0; err_clr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    #1;
    tests++; if (fr !== 4'h0) begin fails++; $display("FAIL reset_fr got %h exp 0", fr); end
    tests++; if (depth !== 3'd0) begin fails++; $display("FAIL reset_depth got %0d exp 0", depth); end
    tests++; if (ovf_err !== 1'b0 || unf_err !== 1'b0) begin
      fails++; $display("FAIL reset_err got ovf=%b unf=%b exp 0 0", ovf_err, unf_err); end
    cond = 4'd1; #1;
    tests++; if (cond_true !== 1'b0) begin fails++; $display("FAIL reset_eq got %b exp 0", cond_true); end
    cond = 4'd2; #1;
    tests++; if (cond_true !== 1'b1) begin fails++; $display("FAIL reset_ne got %b exp 1", cond_true); end
  endtask

  task automatic test_masked();
    alu_flags = 4'b1111; flag_mask = 4'b0101; cond = 4'd1; #1;
    tests++; if (cond_true !== 1'b0) begin fails++; $display("FAIL masked_old_cond got %b exp 0", cond_true); end
    tests++; if (fr !== 4'h0) begin fails++; $display("FAIL masked_no_bypass got %h exp 0", fr); end
    tick();
    tests++; if (fr !== 4'b0101) begin fails++; $display("FAIL masked_fr got %b exp 0101", fr); end
    tests++; if (cond_true !== 1'b1) begin fails++; $display("FAIL masked_new_cond got %b exp 1", cond_true); end
  endtask

  task automatic test_conditions();
    int cc[5]  = '{12, 11, 10, 9, 3};
    bit exp[5] = '{1, 0, 1, 0, 1};
    // SUB 3-5: result negative, nonzero, borrow, no overflow
    alu_flags = 4'b1010; flag_mask = 4'hF;
    tick();
    tests++; if (fr !== 4'b1010) begin fails++; $display("FAIL cond_fr got %b exp 1010", fr); end
    for (int i = 0; i < 5; i++) begin
      cond = 4'(cc[i]); #1;
      tests++; if (cond_true !== exp[i]) begin
        fails++; $display("FAIL cond_%0d got %b exp %b", cc[i], cond_true, exp[i]); end
    end
    for (int c = 0; c < 16; c++) begin
      cond = 4'(c); #1;
      tests++; if (cond_true !== cond_model(m_fr, c)) begin
        fails++; $display("FAIL cond_table_%0d got %b exp %b", c, cond_true, cond_model(m_fr, c)); end
    end
  endtask

  task automatic test_nesting();
    fr_we = 1; fr_wdata = 4'hA; tick();
    push = 1; tick();
    fr_we = 1; fr_wdata = 4'h3; tick();
    push = 1; tick();
    tests++; if (depth !== 3'd2) begin fails++; $display("FAIL nest_depth2 got %0d exp 2", depth); end
    pop = 1; tick();
    tests++; if (fr !== 4'h3 || depth !== 3'd1) begin
      fails++; $display("FAIL nest_pop1 got fr=%h depth=%0d exp fr=3 depth=1", fr, depth); end
    pop = 1; tick();
    tests++; if (fr !== 4'hA || depth !== 3'd0) begin
      fails++; $display("FAIL nest_pop2 got fr=%h depth=%0d exp fr=a depth=0", fr, depth); end
  endtask

  task automatic test_ovf_unf();
    for (int i = 0; i < 5; i++) begin push = 1; tick(); end
    tests++; if (ovf_err !== 1'b1 || depth !== 3'd4) begin
      fails++; $display("FAIL ovf got ovf=%b depth=%0d exp 1 4", ovf_err, depth); end
    for (int i = 0; i < 4; i++) begin pop = 1; tick(); end
    tests++; if (unf_err !== 1'b0 || depth !== 3'd0) begin
      fails++; $display("FAIL drain got unf=%b depth=%0d exp 0 0", unf_err, depth); end
    pop = 1; tick();
    tests++; if (unf_err !== 1'b1 || depth !== 3'd0) begin
      fails++; $display("FAIL unf got unf=%b depth=%0d exp 1 0", unf_err, depth); end
    err_clr = 1; tick();
    tests++; if (ovf_err !== 1'b0 || unf_err !== 1'b0) begin
      fails++; $display("FAIL err_clr got ovf=%b unf=%b exp 0 0", ovf_err, unf_err); end
    pop = 1; err_clr = 1; tick();
    tests++; if (unf_err !== 1'b1) begin fails++; $display("FAIL clr_vs_new got %b exp 1", unf_err); end
    err_clr = 1; tick();
  endtask

  task automatic test_collisions();
    fr_we = 1; fr_wdata = 4'h7; tick();
    push = 1; tick();
    push = 1; pop = 1; tick();
    tests++; if (depth !== 3'd1 || fr !== 4'h7 || ovf_err !== 1'b0 || unf_err !== 1'b0) begin
      fails++; $display("FAIL push_pop got depth=%0d fr=%h exp depth=1 fr=7", depth, fr); end
    pop = 1; fr_we = 1; fr_wdata = 4'hC; alu_flags = 4'hF; flag_mask = 4'hF; tick();
    tests++; if (fr !== 4'h7 || depth !== 3'd0) begin
      fails++; $display("FAIL pop_we got fr=%h depth=%0d exp fr=7 depth=0", fr, depth); end
    fr_we = 1; fr_wdata = 4'h9; tick();
    push = 1; alu_flags = 4'h6; flag_mask = 4'hF; tick();
    tests++; if (fr !== 4'h6 || depth !== 3'd1) begin
      fails++; $display("FAIL push_mask got fr=%h depth=%0d exp fr=6 depth=1", fr, depth); end
    pop = 1; tick();
    tests++; if (fr !== 4'h9) begin fails++; $display("FAIL push_mask_saved got %h exp 9", fr); end
  endtask

  task automatic test_async_reset();
    fr_we = 1; fr_wdata = 4'hF; tick();
    push = 1; tick();
    push = 1; #2;
    rst_n = 0; #1;
    model_reset();
    tests++; if (fr !== 4'h0 || depth !== 3'd0) begin
      fails++; $display("FAIL async_rst got fr=%h depth=%0d exp 0 0", fr, depth); end
    @(posedge clk); #1;
    tests++; if (depth !== 3'd0) begin fails++; $display("FAIL rst_hold got %0d exp 0", depth); end
    idle();
    rst_n = 1; #1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      alu_flags = 4'($urandom);
      flag_mask = 4'($urandom);
      fr_we     = ($urandom_range(0, 4) == 0);
      fr_wdata  = 4'($urandom);
      push      = ($urandom_range(0, 2) == 0);
      pop       = ($urandom_range(0, 2) == 0);
      err_clr   = ($urandom_range(0, 9) == 0);
      tick();
      cond = 4'($urandom); #1;
      tests++;
      if (fr !== 4'(m_fr) || depth !== 3'(m_stack.size()) || ovf_err !== m_ovf ||
          unf_err !== m_unf || cond_true !== cond_model(m_fr, int'(cond))) begin
        fails++;
        $display("FAIL random_%0d got fr=%h d=%0d o=%b u=%b ct=%b exp fr=%h d=%0d o=%b u=%b ct=%b",
                 n, fr, depth, ovf_err, unf_err, cond_true, 4'(m_fr), m_stack.size(),
                 m_ovf, m_unf, cond_model(m_fr, int'(cond)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_masked();
    test_conditions();
    test_nesting();
    test_ovf_unf();
    test_collisions();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
